// File: rtl/thermal_pkg.sv
// ----------------------------------------------------------------------------
// thermal_pkg
//   Shared definitions for the room thermal plant model, the AC controller
//   that drives it and the benches around them.
//   - temp_t        : 5-bit unsigned room temperature
//   - TEMP_MAX/MIN  : saturation limits of temp_t
//   - mode_e        : actuator mode sampled from heating/cooling
//   - PRESC_W       : width of the rate prescaler counter
//   - decode_mode   : maps the two actuator requests onto mode_e
// ----------------------------------------------------------------------------
package thermal_pkg;

    localparam int TEMP_W  = 5;
    localparam int PRESC_W = 8;

    typedef logic [TEMP_W-1:0] temp_t;

    localparam temp_t TEMP_MAX = 5'd31;
    localparam temp_t TEMP_MIN = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HEAT  = 2'd1,
        COOL  = 2'd2,
        FAULT = 2'd3
    } mode_e;

    function automatic mode_e decode_mode(input logic heating, input logic cooling);
        mode_e m;
        case ({heating, cooling})
            2'b10:   m = HEAT;
            2'b01:   m = COOL;
            2'b11:   m = FAULT;
            default: m = IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/thermal_prescaler.sv
// ----------------------------------------------------------------------------
// thermal_prescaler
//   Rate divider for the thermal model. Counts edges and raises tick for
//   the single cycle in which the count sits at div-1; the count wraps to 0
//   on that edge. restart and hold both clear the count without ticking,
//   so any partial count is discarded.
//   Ports:
//     clk      in  : clock, posedge
//     rst_n    in  : synchronous active-low reset
//     restart  in  : mode changed this cycle, clear count
//     hold     in  : actuators in conflict, keep count at 0
//     div[7:0] in  : cycles per tick, 1..255
//     tick     out : one-cycle step enable
// ----------------------------------------------------------------------------
module thermal_prescaler
    import thermal_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               hold,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic [PRESC_W-1:0] term;

    always_comb begin
        term  = div - 8'd1;
        tick  = 1'b0;
        cnt_d = cnt_q + 8'd1;
        if (restart || hold) begin
            cnt_d = '0;
        end else if (cnt_q == term) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/room_thermal_model.sv
// ----------------------------------------------------------------------------
// room_thermal_model
//   Closed-loop plant for the AC exercise. The room temperature climbs while
//   heating, falls while cooling and drifts toward AMBIENT when both
//   actuators are off. Each rate comes from a prescaler; a conflicting
//   heating+cooling request freezes the temperature and raises fault.
//   Ports:
//     clk       in  : clock, posedge
//     rst_n     in  : synchronous active-low reset
//     heating   in  : heater request
//     cooling   in  : cooler request
//     temp      out : registered room temperature, 5-bit unsigned
//     temp_step out : one-cycle pulse on the edge where temp changed
//     fault     out : registered, high while both requests are asserted
// ----------------------------------------------------------------------------
module room_thermal_model
    import thermal_pkg::*;
#(
    parameter int unsigned INIT_TEMP = 20,
    parameter int unsigned AMBIENT   = 24,
    parameter int unsigned HEAT_DIV  = 4,
    parameter int unsigned COOL_DIV  = 4,
    parameter int unsigned DRIFT_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heating,
    input  logic       cooling,
    output logic [4:0] temp,
    output logic       temp_step,
    output logic       fault
);

    localparam temp_t              INIT_C  = temp_t'(INIT_TEMP);
    localparam temp_t              AMB_C   = temp_t'(AMBIENT);
    localparam logic [PRESC_W-1:0] HEAT_C  = PRESC_W'(HEAT_DIV);
    localparam logic [PRESC_W-1:0] COOL_C  = PRESC_W'(COOL_DIV);
    localparam logic [PRESC_W-1:0] DRIFT_C = PRESC_W'(DRIFT_DIV);

    // Saturating arithmetic: the room never wraps past either limit.
    function automatic temp_t sat_inc(input temp_t t);
        return (t == TEMP_MAX) ? t : t + 5'd1;
    endfunction

    function automatic temp_t sat_dec(input temp_t t);
        return (t == TEMP_MIN) ? t : t - 5'd1;
    endfunction

    function automatic temp_t toward_ambient(input temp_t t);
        temp_t r;
        if (t < AMB_C)      r = t + 5'd1;
        else if (t > AMB_C) r = t - 5'd1;
        else                r = t;
        return r;
    endfunction

    mode_e              mode_d, mode_q;
    temp_t              temp_d, temp_q;
    logic               step_q;
    logic               fault_q;
    logic               restart;
    logic               hold;
    logic               tick;
    logic [PRESC_W-1:0] div_sel;

    always_comb begin
        mode_d  = decode_mode(heating, cooling);
        restart = (mode_d != mode_q);
        hold    = (mode_d == FAULT);
        case (mode_d)
            HEAT:    div_sel = HEAT_C;
            COOL:    div_sel = COOL_C;
            default: div_sel = DRIFT_C;  // FAULT holds the counter, value unused
        endcase
    end

    thermal_prescaler u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .hold    (hold),
        .div     (div_sel),
        .tick    (tick)
    );

    // tick is never raised on a mode-change edge, so mode_d == mode_q here.
    always_comb begin
        temp_d = temp_q;
        if (tick) begin
            case (mode_d)
                HEAT:    temp_d = sat_inc(temp_q);
                COOL:    temp_d = sat_dec(temp_q);
                IDLE:    temp_d = toward_ambient(temp_q);
                default: temp_d = temp_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= IDLE;
            temp_q  <= INIT_C;
            step_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            temp_q  <= temp_d;
            step_q  <= (temp_d != temp_q);
            fault_q <= (mode_d == FAULT);
        end
    end

    assign temp      = temp_q;
    assign temp_step = step_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_room_thermal_model.sv
module tb_room_thermal_model;
    import thermal_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       heating = 1'b0;
    logic       cooling = 1'b0;
    logic [4:0] temp;
    logic       temp_step;
    logic       fault;

    int checks = 0;
    int errors = 0;

    room_thermal_model #(
        .INIT_TEMP (20),
        .AMBIENT   (24),
        .HEAT_DIV  (4),
        .COOL_DIV  (1),
        .DRIFT_DIV (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .heating   (heating),
        .cooling   (cooling),
        .temp      (temp),
        .temp_step (temp_step),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts temp_step pulses over n edges, sampling after each edge.
    task automatic count_steps(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            edges(1);
            if (temp_step === 1'b1) pulses++;
        end
    endtask

    // One reset edge with the given actuator inputs; reset released after it.
    task automatic do_reset(input logic h, input logic c);
        rst_n   = 1'b0;
        heating = h;
        cooling = c;
        edges(1);
        chk("rst_temp",  int'(temp), 20);
        chk("rst_step",  int'(temp_step), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;

        // ---- idle drift toward ambient (edge 0 = reset edge) ----
        do_reset(1'b0, 1'b0);
        edges(15);
        chk("idle_e15_temp", int'(temp), 20);
        edges(1);
        chk("idle_e16_temp", int'(temp), 21);
        chk("idle_e16_step", int'(temp_step), 1);
        edges(1);
        chk("idle_e17_step", int'(temp_step), 0);
        edges(15);
        chk("idle_e32_temp", int'(temp), 22);
        chk("idle_e32_step", int'(temp_step), 1);
        edges(32);
        chk("idle_e64_temp", int'(temp), 24);
        count_steps(40, pulses);
        chk("idle_ambient_pulses", pulses, 0);
        chk("idle_ambient_temp", int'(temp), 24);

        // ---- heating, DIV 4, then saturation at 31 ----
        do_reset(1'b1, 1'b0);
        edges(1);                      // E0
        chk("heat_e0_temp", int'(temp), 20);
        edges(3);
        chk("heat_e3_temp", int'(temp), 20);
        chk("heat_e3_step", int'(temp_step), 0);
        edges(1);
        chk("heat_e4_temp", int'(temp), 21);
        chk("heat_e4_step", int'(temp_step), 1);
        edges(1);
        chk("heat_e5_step", int'(temp_step), 0);
        edges(3);
        chk("heat_e8_temp", int'(temp), 22);
        chk("heat_e8_step", int'(temp_step), 1);
        edges(36);
        chk("heat_e44_temp", int'(temp), int'(TEMP_MAX));
        chk("heat_e44_step", int'(temp_step), 1);
        count_steps(20, pulses);
        chk("heat_sat_pulses", pulses, 0);
        chk("heat_sat_temp", int'(temp), 31);

        // ---- cooling, DIV 1, saturation at 0 ----
        do_reset(1'b0, 1'b1);
        edges(1);                      // E0
        chk("cool_e0_temp", int'(temp), 20);
        edges(1);
        chk("cool_e1_temp", int'(temp), 19);
        edges(18);
        chk("cool_e19_temp", int'(temp), 1);
        edges(1);
        chk("cool_e20_temp", int'(temp), int'(TEMP_MIN));
        chk("cool_e20_step", int'(temp_step), 1);
        count_steps(180, pulses);
        chk("cool_sat_pulses", pulses, 0);
        chk("cool_sat_temp", int'(temp), 0);

        // ---- conflicting requests mid-count ----
        do_reset(1'b1, 1'b0);
        edges(1);                      // E0 heat
        edges(2);                      // count partially advanced
        cooling = 1'b1;
        edges(1);
        chk("fault_rise", int'(fault), 1);
        chk("fault_rise_temp", int'(temp), 20);
        count_steps(9, pulses);
        chk("fault_hold_pulses", pulses, 0);
        chk("fault_hold", int'(fault), 1);
        chk("fault_hold_temp", int'(temp), 20);
        cooling = 1'b0;
        edges(1);                      // release edge = new E0
        chk("fault_fall", int'(fault), 0);
        edges(3);
        chk("fault_rel3_temp", int'(temp), 20);
        edges(1);
        chk("fault_rel4_temp", int'(temp), 21);
        chk("fault_rel4_step", int'(temp_step), 1);

        // ---- reset mid-operation at 27 while heating ----
        do_reset(1'b1, 1'b0);
        edges(1);                      // E0
        edges(28);
        chk("pre_rst_temp", int'(temp), 27);
        edges(2);                      // partial count
        cooling = 1'b1;                // conflict during reset must not raise fault
        do_reset(1'b1, 1'b1);
        cooling = 1'b0;
        edges(1);                      // E0 after reset (mode_q was IDLE)
        chk("post_rst_e0_temp", int'(temp), 20);
        chk("post_rst_e0_fault", int'(fault), 0);
        edges(3);
        chk("post_rst_e3_temp", int'(temp), 20);
        edges(1);
        chk("post_rst_e4_temp", int'(temp), 21);
        chk("post_rst_e4_step", int'(temp_step), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
